// File: rtl/ula_arbiter_if.sv
// Request/response and ULA-side signals of the two-port ULA arbiter.
// The arbiter uses the slave modport; requesters and the ULA sit on the master side.
interface ula_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [2:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [2:0]       req1_op;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [WIDTH-1:0] rsp0_result;
    logic             rsp0_z;

    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp1_result;
    logic             rsp1_z;

    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [2:0]       ula_control;
    logic [WIDTH-1:0] ula_result;
    logic             z;

    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp0_ready, rsp1_ready,
        input  ula_result, z,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_result, rsp0_z,
        output rsp1_valid, rsp1_result, rsp1_z,
        output src_a, src_b, ula_control,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp0_ready, rsp1_ready,
        output ula_result, z,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_result, rsp0_z,
        input  rsp1_valid, rsp1_result, rsp1_z,
        input  src_a, src_b, ula_control,
        input  busy
    );
endinterface

// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one combinational ULA between two requesters,
// with a single outstanding transaction: accept, one execute cycle, then hold response.
module ula_arbiter #(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          rst,
    ula_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic             last;
    logic             owner;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             rsp_done;

    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [2:0]       ula_control;
    logic [WIDTH-1:0] result0;
    logic [WIDTH-1:0] result1;
    logic             z0;
    logic             z1;

    // Contested grant goes to the port not served last; uncontested to whoever asks.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            grant0 = bus.req0_valid & (~bus.req1_valid | last);
            grant1 = bus.req1_valid & (~bus.req0_valid | ~last);
        end
    end

    assign accept   = grant0 | grant1;
    assign rsp_done = (state == RESP) & (owner ? bus.rsp1_ready : bus.rsp0_ready);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)   state_next = EXEC;
            EXEC:                  state_next = RESP;
            RESP:    if (rsp_done) state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last        <= 1'b1;
            owner       <= 1'b0;
            src_a       <= '0;
            src_b       <= '0;
            ula_control <= '0;
        end else if (accept) begin
            last        <= grant1;
            owner       <= grant1;
            src_a       <= grant1 ? bus.req1_a  : bus.req0_a;
            src_b       <= grant1 ? bus.req1_b  : bus.req0_b;
            ula_control <= grant1 ? bus.req1_op : bus.req0_op;
        end
    end

    // Per-port result registers persist after the handshake; only rsp*_valid qualifies them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result0 <= '0;
            result1 <= '0;
            z0      <= 1'b0;
            z1      <= 1'b0;
        end else if (state == EXEC) begin
            if (owner) begin
                result1 <= bus.ula_result;
                z1      <= bus.z;
            end else begin
                result0 <= bus.ula_result;
                z0      <= bus.z;
            end
        end
    end

    assign bus.req0_ready  = grant0;
    assign bus.req1_ready  = grant1;
    assign bus.rsp0_valid  = (state == RESP) & ~owner;
    assign bus.rsp1_valid  = (state == RESP) & owner;
    assign bus.rsp0_result = result0;
    assign bus.rsp1_result = result1;
    assign bus.rsp0_z      = z0;
    assign bus.rsp1_z      = z1;
    assign bus.src_a       = src_a;
    assign bus.src_b       = src_b;
    assign bus.ula_control = ula_control;
    assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_ula_arbiter.sv
// Bench for ula_arbiter: behavioural ULA on the bus, transaction-level reference model
// for grants, latency and results, directed steps followed by randomized transactions.
module tb_ula_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    // Reference model state: port served last and each port's last captured response.
    int         model_last;
    logic [7:0] model_res [2];
    logic       model_z   [2];

    ula_arbiter_if #(.WIDTH(8)) bus ();

    ula_arbiter #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [7:0] ula_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b101:  return (a < b) ? 8'h01 : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        bus.ula_result = ula_ref(bus.src_a, bus.src_b, bus.ula_control);
        bus.z          = (bus.ula_result == 8'h00);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        model_last   = 1;
        model_res[0] = 8'h00;
        model_res[1] = 8'h00;
        model_z[0]   = 1'b0;
        model_z[1]   = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " busy"},    8'(bus.busy),        8'h00);
        check({tag, " rsp0_v"},  8'(bus.rsp0_valid),  8'h00);
        check({tag, " rsp1_v"},  8'(bus.rsp1_valid),  8'h00);
        check({tag, " rsp0_r"},  bus.rsp0_result,     8'h00);
        check({tag, " rsp1_r"},  bus.rsp1_result,     8'h00);
        check({tag, " rsp0_z"},  8'(bus.rsp0_z),      8'h00);
        check({tag, " rsp1_z"},  8'(bus.rsp1_z),      8'h00);
        check({tag, " src_a"},   bus.src_a,           8'h00);
        check({tag, " src_b"},   bus.src_b,           8'h00);
        check({tag, " ctl"},     8'(bus.ula_control), 8'h00);
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #1;
        model_reset();
        check_cleared(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One full transaction: present requests, accept, execute, respond after stall cycles.
    task automatic run_txn(input string tag, input logic v0, input logic v1,
                           input logic [7:0] a0, input logic [7:0] b0, input logic [2:0] op0,
                           input logic [7:0] a1, input logic [7:0] b1, input logic [2:0] op1,
                           input int unsigned stall);
        int         g;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [2:0] eop;

        if (v0 && v1) g = 1 - model_last;
        else          g = v0 ? 0 : 1;
        ea  = (g == 1) ? a1  : a0;
        eb  = (g == 1) ? b1  : b0;
        eop = (g == 1) ? op1 : op0;

        @(negedge clk);
        bus.req0_valid = v0;  bus.req0_a = a0;  bus.req0_b = b0;  bus.req0_op = op0;
        bus.req1_valid = v1;  bus.req1_a = a1;  bus.req1_b = b1;  bus.req1_op = op1;
        #1;
        check({tag, " ready0"}, 8'(bus.req0_ready), 8'(g == 0));
        check({tag, " ready1"}, 8'(bus.req1_ready), 8'(g == 1));

        @(posedge clk);
        #1;
        model_last = g;
        check({tag, " exec busy"},   8'(bus.busy),       8'h01);
        check({tag, " exec rdy"},    8'({bus.req0_ready, bus.req1_ready}), 8'h00);
        check({tag, " exec rsp_v"},  8'({bus.rsp0_valid, bus.rsp1_valid}), 8'h00);
        check({tag, " src_a"},       bus.src_a,          ea);
        check({tag, " src_b"},       bus.src_b,          eb);
        check({tag, " ctl"},         8'(bus.ula_control), 8'(eop));

        @(posedge clk);
        #1;
        model_res[g] = ula_ref(ea, eb, eop);
        model_z[g]   = (model_res[g] == 8'h00);
        for (int unsigned k = 0; k <= stall; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            check({tag, " rsp0_v"}, 8'(bus.rsp0_valid), 8'(g == 0));
            check({tag, " rsp1_v"}, 8'(bus.rsp1_valid), 8'(g == 1));
            check({tag, " rsp0_r"}, bus.rsp0_result,    model_res[0]);
            check({tag, " rsp1_r"}, bus.rsp1_result,    model_res[1]);
            check({tag, " rsp0_z"}, 8'(bus.rsp0_z),     8'(model_z[0]));
            check({tag, " rsp1_z"}, 8'(bus.rsp1_z),     8'(model_z[1]));
            check({tag, " resp busy"}, 8'(bus.busy),    8'h01);
            check({tag, " resp rdy"},  8'({bus.req0_ready, bus.req1_ready}), 8'h00);
        end

        @(negedge clk);
        if (g == 1) bus.rsp1_ready = 1'b1;
        else        bus.rsp0_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " done busy"},  8'(bus.busy), 8'h00);
        check({tag, " done rsp_v"}, 8'({bus.rsp0_valid, bus.rsp1_valid}), 8'h00);
        check({tag, " held r"},     (g == 1) ? bus.rsp1_result : bus.rsp0_result, model_res[g]);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_inputs();
        bus.req0_a = 8'h00;  bus.req0_b = 8'h00;  bus.req0_op = 3'b000;
        bus.req1_a = 8'h00;  bus.req1_b = 8'h00;  bus.req1_op = 3'b000;
        model_reset();

        apply_reset("reset");
        check("reset ready0", 8'(bus.req0_ready), 8'h00);
        check("reset ready1", 8'(bus.req1_ready), 8'h00);

        // Single-port operations, including subtract-to-zero, unsigned slt and overflow.
        run_txn("p0 add",  1'b1, 1'b0, 8'h05, 8'h03, 3'b000, 8'h00, 8'h00, 3'b000, 0);
        check("p0 add result", model_res[0], 8'h08);
        run_txn("p1 sub",  1'b0, 1'b1, 8'h00, 8'h00, 3'b000, 8'h07, 8'h07, 3'b001, 0);
        run_txn("p1 slt",  1'b0, 1'b1, 8'h00, 8'h00, 3'b000, 8'h02, 8'h09, 3'b101, 0);
        run_txn("p0 ovf",  1'b1, 1'b0, 8'hFF, 8'h01, 3'b000, 8'h00, 8'h00, 3'b000, 0);
        run_txn("p0 op7",  1'b1, 1'b0, 8'h3C, 8'hA5, 3'b111, 8'h00, 8'h00, 3'b000, 0);

        // Contention from reset: port 0 first, then strict alternation, one with backpressure.
        apply_reset("reset2");
        run_txn("both a", 1'b1, 1'b1, 8'h10, 8'h0F, 3'b011, 8'hF0, 8'h3C, 3'b010, 0);
        check("both a served p0", 8'(model_last), 8'h00);
        run_txn("both b", 1'b1, 1'b1, 8'h10, 8'h0F, 3'b011, 8'hF0, 8'h3C, 3'b010, 0);
        run_txn("both c", 1'b1, 1'b1, 8'h10, 8'h0F, 3'b011, 8'hF0, 8'h3C, 3'b010, 5);
        run_txn("both d", 1'b1, 1'b1, 8'h10, 8'h0F, 3'b011, 8'hF0, 8'h3C, 3'b010, 0);

        // Request withdrawn before any clock edge leaves the block idle and unchanged.
        @(negedge clk);
        bus.req1_valid = 1'b1;  bus.req1_a = 8'h77;  bus.req1_b = 8'h11;  bus.req1_op = 3'b001;
        #1;
        check("withdraw ready1", 8'(bus.req1_ready), 8'h01);
        #2;
        bus.req1_valid = 1'b0;
        @(posedge clk);
        #1;
        check("withdraw busy",  8'(bus.busy), 8'h00);
        check("withdraw src_a", bus.src_a,    8'hF0);

        // Reset in the execute cycle discards the transaction.
        @(negedge clk);
        bus.req0_valid = 1'b1;  bus.req0_a = 8'h21;  bus.req0_b = 8'h12;  bus.req0_op = 3'b000;
        @(posedge clk);
        #1;
        check("mid busy", 8'(bus.busy), 8'h01);
        bus.req0_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_cleared("mid rst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post rst rsp_v", 8'({bus.rsp0_valid, bus.rsp1_valid}), 8'h00);
        run_txn("after rst", 1'b1, 1'b1, 8'h01, 8'h02, 3'b001, 8'h03, 8'h04, 3'b000, 0);
        check("after rst served p0", 8'(model_last), 8'h00);

        // Randomized traffic against the transaction model.
        for (int i = 0; i < 30; i++) begin
            logic v0;
            logic v1;
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            run_txn($sformatf("rand%0d", i), v0, v1,
                    8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                    8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                    $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
